// File: rtl/beep_scheduler_pkg.sv
// rtl/beep_scheduler_pkg.sv - shared encodings and default timing for the beep scheduler
package beep_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_SLOT  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_PULSE = 2'd1,
    SRC_KEY   = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_LOW  = 2'd1;
  localparam logic [1:0] LVL_HIGH = 2'd2;

  // 50 MHz: 25 ms tone + 3 ms gap per slot, 1 s / 0.5 s between alarm bursts
  localparam int DEF_SLOT_CYC   = 1_400_000;
  localparam int DEF_LO_GAP_CYC = 50_000_000;
  localparam int DEF_HI_GAP_CYC = 25_000_000;

  // Beeps still owed after the first strobe of a burst
  localparam logic [1:0] HI_BURST_REST = 2'd2;
  localparam logic [1:0] LO_BURST_REST = 2'd1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/beep_tick_cnt.sv
// rtl/beep_tick_cnt.sv - loadable down-counter timing both tone slots and alarm pauses
module beep_tick_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  // Holds at zero instead of wrapping so done stays asserted until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - arbitrates key, pulse and alarm beeps into spaced Beep.En strobes
module beep_scheduler
  import beep_scheduler_pkg::*;
#(
  parameter int SLOT_CYC   = DEF_SLOT_CYC,
  parameter int LO_GAP_CYC = DEF_LO_GAP_CYC,
  parameter int HI_GAP_CYC = DEF_HI_GAP_CYC
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       key_req,
  input  logic       pulse_req,
  input  logic [1:0] alarm_lvl,
  input  logic       mute,
  output logic       beep_en,
  output logic       busy,
  output logic [1:0] cur_src
);

  localparam int CNT_W = $clog2(max3(SLOT_CYC, LO_GAP_CYC, HI_GAP_CYC));

  // FIRE is the first cycle of the slot, so the counter only covers the rest
  localparam logic [CNT_W-1:0] SLOT_LD = CNT_W'(SLOT_CYC - 2);
  localparam logic [CNT_W-1:0] LO_LD   = CNT_W'(LO_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LD   = CNT_W'(HI_GAP_CYC - 1);

  state_t           state;
  logic             key_pend;
  logic             burst_hi;
  logic [1:0]       beeps_left;
  logic             tick_load;
  logic [CNT_W-1:0] tick_value;
  logic             tick_done;
  logic             alarm_on;
  logic             alarm_hi;
  logic             key_go;
  logic             pulse_go;

  assign alarm_on = (alarm_lvl != LVL_NONE);
  assign alarm_hi = alarm_lvl[1];  // level 3 counts as high
  assign key_go   = !mute && (key_pend || key_req);
  assign pulse_go = !mute && pulse_req;

  // Reloading on every slot expiry is harmless when the next state is not PAUSE
  assign tick_load  = (state == ST_FIRE) || ((state == ST_SLOT) && tick_done);
  assign tick_value = (state == ST_FIRE) ? SLOT_LD : (alarm_hi ? HI_LD : LO_LD);

  beep_tick_cnt #(.W(CNT_W)) u_tick (
    .clk   (Clk),
    .rst_n (Rst_n),
    .load  (tick_load),
    .value (tick_value),
    .done  (tick_done)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      beep_en    <= 1'b0;
      busy       <= 1'b0;
      cur_src    <= SRC_NONE;
      key_pend   <= 1'b0;
      burst_hi   <= 1'b0;
      beeps_left <= 2'd0;
    end else begin
      beep_en <= 1'b0;
      if (mute) begin
        key_pend <= 1'b0;
      end else if (key_req) begin
        key_pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (alarm_on) begin
            state      <= ST_FIRE;
            beep_en    <= 1'b1;
            busy       <= 1'b1;
            cur_src    <= SRC_ALARM;
            burst_hi   <= alarm_hi;
            beeps_left <= alarm_hi ? HI_BURST_REST : LO_BURST_REST;
            key_pend   <= 1'b0;
          end else if (key_go) begin
            state    <= ST_FIRE;
            beep_en  <= 1'b1;
            busy     <= 1'b1;
            cur_src  <= SRC_KEY;
            key_pend <= 1'b0;
          end else if (pulse_go) begin
            state   <= ST_FIRE;
            beep_en <= 1'b1;
            busy    <= 1'b1;
            cur_src <= SRC_PULSE;
          end
        end

        ST_FIRE: state <= ST_SLOT;

        ST_SLOT: begin
          if (tick_done) begin
            if (cur_src == SRC_ALARM) begin
              if (!alarm_on) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                cur_src <= SRC_NONE;
              end else if (alarm_hi && !burst_hi) begin
                state      <= ST_FIRE;
                beep_en    <= 1'b1;
                burst_hi   <= 1'b1;
                beeps_left <= HI_BURST_REST;
                key_pend   <= 1'b0;
              end else if ((alarm_hi == burst_hi) && (beeps_left != 2'd0)) begin
                state      <= ST_FIRE;
                beep_en    <= 1'b1;
                beeps_left <= beeps_left - 2'd1;
              end else begin
                state <= ST_PAUSE;
              end
            end else if (alarm_on) begin
              state      <= ST_FIRE;
              beep_en    <= 1'b1;
              cur_src    <= SRC_ALARM;
              burst_hi   <= alarm_hi;
              beeps_left <= alarm_hi ? HI_BURST_REST : LO_BURST_REST;
              key_pend   <= 1'b0;
            end else if (key_go) begin
              state    <= ST_FIRE;
              beep_en  <= 1'b1;
              cur_src  <= SRC_KEY;
              key_pend <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              cur_src <= SRC_NONE;
            end
          end
        end

        ST_PAUSE: begin
          if (!alarm_on) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            cur_src <= SRC_NONE;
          end else if (tick_done) begin
            state      <= ST_FIRE;
            beep_en    <= 1'b1;
            burst_hi   <= alarm_hi;
            beeps_left <= alarm_hi ? HI_BURST_REST : LO_BURST_REST;
            key_pend   <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          cur_src <= SRC_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/beep_scheduler.md
# beep_scheduler

Sequences and arbitrates all audible feedback in the HR/SpO2 front panel. It accepts key-click requests, heart-beat pulse requests and a two-level vital-sign alarm, and issues single-cycle `En` strobes to the existing `Beep` tone generator. Strobes are spaced so that a tone is never retriggered while still sounding. Sits between the key/measurement logic and `Beep`; `beep_en` wires directly to `Beep.En`.

## Interface
- `SLOT_CYC`, 1_400_000: cycles reserved per tone (25 ms tone + 3 ms gap at 50 MHz); minimum `beep_en` spacing.
- `LO_GAP_CYC`, 50_000_000: pause between low-alarm bursts (1 s).
- `HI_GAP_CYC`, 25_000_000: pause between high-alarm bursts (0.5 s).
- `Clk`  in  1  system clock, 50 MHz.
- `Rst_n`  in  1  asynchronous active-low reset.
- `key_req`  in  1  one-cycle pulse, key press click.
- `pulse_req`  in  1  one-cycle pulse, detected heart beat.
- `alarm_lvl`  in  2  level: 0 none, 1 low, 2 high, 3 treated as high.
- `mute`  in  1  level; suppresses key and pulse sources only, never alarms.
- `beep_en`  out  1  one-cycle strobe to `Beep.En`.
- `busy`  out  1  high whenever state is not IDLE.
- `cur_src`  out  2  source being served: 0 none, 1 pulse, 2 key, 3 alarm.

## Operation
- States: IDLE, FIRE, SLOT, PAUSE.
- Priority at any decision point: alarm high > alarm low > key > pulse.
- IDLE: alarm_lvl≠0 → FIRE (burst of 3 beeps if high, 2 if low). Else if key_pend or key_req (mute low) → FIRE, 1 beep. Else if pulse_req (mute low) → FIRE, 1 beep.
- FIRE: one cycle; `beep_en`=1; load slot counter; → SLOT.
- SLOT: counts `SLOT_CYC` cycles from the FIRE cycle inclusive. On expiry, re-evaluate: alarm burst with beeps remaining and alarm still set → FIRE. Alarm burst complete, or alarm level changed → PAUSE with gap of the current level (level raised lo→hi: skip PAUSE, start a fresh 3-beep burst). alarm_lvl=0 → IDLE with remaining beeps aborted. Non-alarm slot → IDLE.
- PAUSE: counts gap; on expiry, alarm_lvl≠0 → new burst at current level; else → IDLE. alarm_lvl dropping to 0 during PAUSE → IDLE next cycle.
- key_pend: set by key_req (mute low) whenever the request is not consumed immediately; single-deep (extra presses lost); cleared when served or when an alarm burst starts; cleared by mute.
- pulse_req while busy: discarded, never queued.
- key_req and pulse_req in the same IDLE cycle: key served, pulse discarded.
- Alarm rising while a key/pulse slot runs: slot completes unmodified, then burst starts.

## Timing
- Reset: `beep_en`=0, `busy`=0, `cur_src`=0, state IDLE, all counters and key_pend 0. Reset mid-tone drops everything immediately; next strobe is possible no earlier than the cycle after first sampled request.
- Latency: request sampled at edge k in IDLE → `beep_en` high during cycle k+1 (exactly one cycle).
- Consecutive strobes within a burst: exactly `SLOT_CYC` cycles apart.
- Burst to next burst (unchanged level): last strobe + `SLOT_CYC` + gap cycles.
- `busy` rises with FIRE, falls the cycle IDLE is re-entered. `cur_src` valid for FIRE/SLOT/PAUSE, 0 in IDLE.
- Counters sized `$clog2` of the largest parameter; terminal count compares to parameter−1, no wrap.

## Structure
- Shared header `beep_defs.vh`: state encodings, `cur_src` encodings, alarm level codes, default cycle constants.
- One sub-module natural: `beep_tick_cnt`, a loadable down-counter with `done` flag, instanced once and reused for slot and pause timing.

## Test plan
Bench parameters: `SLOT_CYC`=10, `LO_GAP_CYC`=40, `HI_GAP_CYC`=20.
- Single key_req after reset → one `beep_en` one cycle later, `cur_src`=2, `busy` high 10 cycles, then IDLE.
- key_req, then 3 more key_req during the slot → exactly two strobes, 10 cycles apart.
- alarm_lvl=2 held → strobes at t, t+10, t+20, next burst at t+50; alarm_lvl=1 → 2 strobes, bursts 60 cycles apart.
- alarm_lvl 1→2 during 2nd low slot → fresh 3-beep burst starts immediately after the slot; 2→0 mid-burst → no further strobes, IDLE after current slot.
- mute=1 with key_req/pulse_req → no strobes; mute=1 with alarm_lvl=2 → alarm pattern unchanged.
- Rst_n low during SLOT → `beep_en`/`busy`/`cur_src` 0 asynchronously; pending key lost.
